cla_multiword_sequencer: RTL and testbench

//  Adds two NUM_SLICES*5-bit operands by driving the 5-bit cla_final adder one slice per pass, LSB slice first.

---
 rtl/cla_multiword_sequencer.sv | 124 ++++++++++++
 tb/tb_cla_multiword_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_multiword_sequencer.sv
// Multi-word adder sequencer: runs an external 5-bit cla_final one slice per pass, LSB first.
// Optional signed-overflow output enabled by defining CLA_SIGNED_OVF_EN.
module cla_multiword_sequencer #(
    parameter int NUM_SLICES = 4,
    parameter int CLA_LAT    = 2,
    localparam int W         = NUM_SLICES * 5
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         start,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         cin,
    output logic [4:0]   a_slice,
    output logic [4:0]   b_slice,
    output logic         cin_slice,
    input  logic [4:0]   s_slice,
    input  logic         cout_slice,
    output logic         busy,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         done
`ifdef CLA_SIGNED_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int KW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam int PW = (CLA_LAT > 0) ? $clog2(CLA_LAT + 1) : 1;
    localparam logic [KW-1:0] K_LAST  = KW'(NUM_SLICES - 1);
    localparam logic [PW-1:0] PH_LAST = PW'(CLA_LAT);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_reg;
    logic [KW-1:0]  k_reg;
    logic [PW-1:0]  ph_reg;
    logic [W-1:0]   op_a_reg;
    logic [W-1:0]   op_b_reg;
    logic [W-1:0]   staging_reg;
    logic [W-1:0]   staging_next;
    logic [KW-1:0]  k_next;
    logic [4:0]     a_parts [NUM_SLICES];
    logic [4:0]     b_parts [NUM_SLICES];

    assign k_next = k_reg + KW'(1);

    // staging_next is the staging word with the current slice's result merged in
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLICES; gi++) begin : g_slice
            assign a_parts[gi] = op_a_reg[gi*5 +: 5];
            assign b_parts[gi] = op_b_reg[gi*5 +: 5];
            assign staging_next[gi*5 +: 5] = (k_reg == KW'(gi)) ? s_slice
                                                                : staging_reg[gi*5 +: 5];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= IDLE;
            k_reg       <= '0;
            ph_reg      <= '0;
            op_a_reg    <= '0;
            op_b_reg    <= '0;
            staging_reg <= '0;
            a_slice     <= '0;
            b_slice     <= '0;
            cin_slice   <= 1'b0;
            busy        <= 1'b0;
            sum         <= '0;
            cout        <= 1'b0;
            done        <= 1'b0;
`ifdef CLA_SIGNED_OVF_EN
            ovf         <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        op_a_reg  <= op_a;
                        op_b_reg  <= op_b;
                        a_slice   <= op_a[4:0];
                        b_slice   <= op_b[4:0];
                        cin_slice <= cin;
                        busy      <= 1'b1;
                        k_reg     <= '0;
                        ph_reg    <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (ph_reg != PH_LAST) begin
                        ph_reg <= ph_reg + PW'(1);
                    end else begin
                        staging_reg <= staging_next;
                        if (k_reg != K_LAST) begin
                            // cin_slice doubles as the inter-slice carry register
                            k_reg     <= k_next;
                            ph_reg    <= '0;
                            a_slice   <= a_parts[k_next];
                            b_slice   <= b_parts[k_next];
                            cin_slice <= cout_slice;
                        end else begin
                            sum       <= staging_next;
                            cout      <= cout_slice;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state_reg <= IDLE;
`ifdef CLA_SIGNED_OVF_EN
                            ovf <= (op_a_reg[W-1] == op_b_reg[W-1]) &&
                                   (staging_next[W-1] != op_a_reg[W-1]);
`endif
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_multiword_sequencer.sv
// Bench for cla_multiword_sequencer with a behavioural pipelined 5-bit cla_final model.
// Expected results come from a wide behavioural add pushed to a scoreboard queue.
module tb_cla_multiword_sequencer;

    localparam int NUM_SLICES = 4;
    localparam int CLA_LAT    = 2;
    localparam int W          = NUM_SLICES * 5;
    localparam int PASS       = CLA_LAT + 1;
    localparam int LAT        = NUM_SLICES * PASS;

    typedef struct {
        logic [W-1:0]          sum;
        logic                  cout;
        logic                  ovf;
        logic [NUM_SLICES-1:0] carries;
    } exp_t;

    logic           CLK = 1'b0;
    logic           RST;
    logic           start;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic           cin;
    logic [4:0]     a_slice;
    logic [4:0]     b_slice;
    logic           cin_slice;
    logic [4:0]     s_slice;
    logic           cout_slice;
    logic           busy;
    logic [W-1:0]   sum;
    logic           cout;
    logic           done;
`ifdef CLA_SIGNED_OVF_EN
    logic           ovf;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 CLK = ~CLK;

    cla_multiword_sequencer #(.NUM_SLICES(NUM_SLICES), .CLA_LAT(CLA_LAT)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .a_slice   (a_slice),
        .b_slice   (b_slice),
        .cin_slice (cin_slice),
        .s_slice   (s_slice),
        .cout_slice(cout_slice),
        .busy      (busy),
        .sum       (sum),
        .cout      (cout),
        .done      (done)
`ifdef CLA_SIGNED_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // cla_final stand-in: CLA_LAT registered stages from inputs to outputs
    logic [5:0] cla_pipe [CLA_LAT];
    always @(posedge CLK) begin
        cla_pipe[0] <= {1'b0, a_slice} + {1'b0, b_slice} + {5'd0, cin_slice};
        for (int i = 1; i < CLA_LAT; i++) cla_pipe[i] <= cla_pipe[i-1];
    end
    assign s_slice    = cla_pipe[CLA_LAT-1][4:0];
    assign cout_slice = cla_pipe[CLA_LAT-1][5];

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        exp_t         e;
        logic [W:0]   full;
        logic [W:0]   part;
        logic [W-1:0] mask;
        full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
        e.carries = '0;
        e.carries[0] = c;
        for (int k = 1; k < NUM_SLICES; k++) begin
            mask = {W{1'b1}} >> (W - 5*k);
            part = {1'b0, a & mask} + {1'b0, b & mask} + {{W{1'b0}}, c};
            e.carries[k] = part[5*k];
        end
        return e;
    endfunction

    // Entered and left on a negedge. One op, checking carry chain, latency and result.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input string tag);
        exp_t e;
        exp_t got;
        int   n;
        bit   seen;
        e = model(a, b, c);
        sb.push_back(e);
        start = 1'b1; op_a = a; op_b = b; cin = c;
        @(posedge CLK); @(negedge CLK);
        start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
        n = 0; seen = 0;
        while (!seen && n < LAT + 8) begin
            if ((n % PASS) == 0 && n < LAT) begin
                checks++;
                if (cin_slice !== e.carries[n/PASS]) begin
                    failures++;
                    $display("FAIL %s carry_in slice%0d: got %b want %b", tag, n/PASS, cin_slice, e.carries[n/PASS]);
                end
            end
            @(posedge CLK); n++; @(negedge CLK);
            if (done === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || n != LAT) begin
            failures++;
            $display("FAIL %s latency: got %0d (seen=%0d) want %0d", tag, n, seen, LAT);
        end
        if (seen && sb.size() > 0) begin
            got = sb.pop_front();
            checks++;
            if (sum !== got.sum || cout !== got.cout || busy !== 1'b0) begin
                failures++;
                $display("FAIL %s result: got sum=%h cout=%b busy=%b want sum=%h cout=%b busy=0",
                         tag, sum, cout, busy, got.sum, got.cout);
            end
`ifdef CLA_SIGNED_OVF_EN
            checks++;
            if (ovf !== got.ovf) begin
                failures++;
                $display("FAIL %s ovf: got %b want %b", tag, ovf, got.ovf);
            end
`endif
        end else if (!seen) begin
            void'(sb.pop_front());
        end
        $display("op %s a=%h b=%h cin=%b -> sum=%h cout=%b", tag, a, b, c, sum, cout);
    endtask

    task automatic test_reset();
        RST = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK); @(negedge CLK);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0 ||
            a_slice !== 5'd0 || b_slice !== 5'd0 || cin_slice !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got busy=%b done=%b sum=%h cout=%b a=%h b=%h ci=%b want all zero",
                     busy, done, sum, cout, a_slice, b_slice, cin_slice);
        end
        $display("reset: busy=%b done=%b sum=%h cout=%b", busy, done, sum, cout);
    endtask

    task automatic test_basic();
        do_op(20'h00003, 20'h00004, 1'b0, "basic");
    endtask

    task automatic test_full_ripple();
        do_op(20'hFFFFF, 20'h00000, 1'b1, "ripple");
    endtask

    task automatic test_start_ignored();
        exp_t e;
        exp_t got;
        int   n;
        int   dones;
        int   done_at;
        bit   busy_drop;
        e = model(20'hABCDE, 20'h13579, 1'b0);
        sb.push_back(e);
        start = 1'b1; op_a = 20'hABCDE; op_b = 20'h13579; cin = 1'b0;
        @(posedge CLK); @(negedge CLK);
        start = 1'b0; op_a = '0; op_b = '0;
        n = 0; dones = 0; done_at = -1; busy_drop = 0;
        while (n < LAT + 8) begin
            start = (n == 2 || n == 6);
            op_a  = start ? 20'h55555 : '0;
            op_b  = start ? 20'h0F0F0 : '0;
            cin   = start;
            @(posedge CLK); n++; @(negedge CLK);
            if (n < LAT && busy !== 1'b1) busy_drop = 1;
            if (done === 1'b1) begin
                dones++;
                done_at = n;
                if (sb.size() > 0) begin
                    got = sb.pop_front();
                    checks++;
                    if (sum !== got.sum || cout !== got.cout) begin
                        failures++;
                        $display("FAIL ignore_start result: got %h/%b want %h/%b", sum, cout, got.sum, got.cout);
                    end
                end
            end
        end
        start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
        checks++;
        if (busy_drop) begin
            failures++;
            $display("FAIL ignore_start busy: got busy dropped early want busy held");
        end
        checks++;
        if (dones != 1 || done_at != LAT) begin
            failures++;
            $display("FAIL ignore_start done: got %0d pulses at %0d want 1 at %0d", dones, done_at, LAT);
        end
        $display("ignore_start: sum=%h cout=%b dones=%0d", sum, cout, dones);
    endtask

    task automatic test_reset_mid_op();
        int n;
        bit done_seen;
        start = 1'b1; op_a = 20'h11111; op_b = 20'h22222; cin = 1'b0;
        @(posedge CLK); @(negedge CLK);
        start = 1'b0; op_a = '0; op_b = '0;
        repeat (4) begin @(posedge CLK); @(negedge CLK); end
        RST = 1'b1;
        @(posedge CLK); @(negedge CLK);
        RST = 1'b0;
        checks++;
        if (busy !== 1'b0 || sum !== '0 || cout !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_op: got busy=%b sum=%h cout=%b done=%b want 0/0/0/0", busy, sum, cout, done);
        end
        done_seen = 0;
        for (n = 0; n < LAT + 4; n++) begin
            @(posedge CLK); @(negedge CLK);
            if (done === 1'b1) done_seen = 1;
        end
        checks++;
        if (done_seen) begin
            failures++;
            $display("FAIL reset_mid_op no_done: got done pulse want none");
        end
        $display("reset_mid_op: busy=%b sum=%h", busy, sum);
        do_op(20'h2468A, 20'h13579, 1'b1, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] av [3];
        logic [W-1:0] bv [3];
        logic         cv [3];
        int   acc_at  [3];
        int   done_at [3];
        int   acc_n;
        int   done_n;
        int   n;
        bit   busy_prev;
        exp_t got;
        av[0] = 20'h7FFFF; bv[0] = 20'h00001; cv[0] = 1'b0;
        av[1] = 20'h12345; bv[1] = 20'h0ABCD; cv[1] = 1'b0;
        av[2] = 20'hFFFFF; bv[2] = 20'hFFFFF; cv[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(model(av[i], bv[i], cv[i]));
            acc_at[i] = -1; done_at[i] = -1;
        end
        acc_n = 0; done_n = 0; busy_prev = busy;
        start = 1'b1; op_a = av[0]; op_b = bv[0]; cin = cv[0];
        for (n = 1; n <= 3 * (LAT + 1) + 6; n++) begin
            @(posedge CLK); @(negedge CLK);
            if (done === 1'b1 && done_n < 3) begin
                done_at[done_n] = n;
                if (sb.size() > 0) begin
                    got = sb.pop_front();
                    checks++;
                    if (sum !== got.sum || cout !== got.cout) begin
                        failures++;
                        $display("FAIL b2b result%0d: got %h/%b want %h/%b", done_n, sum, cout, got.sum, got.cout);
                    end
`ifdef CLA_SIGNED_OVF_EN
                    checks++;
                    if (ovf !== got.ovf) begin
                        failures++;
                        $display("FAIL b2b ovf%0d: got %b want %b", done_n, ovf, got.ovf);
                    end
`endif
                end
                $display("b2b op%0d done at edge %0d: sum=%h cout=%b", done_n, n, sum, cout);
                done_n++;
            end
            if (!busy_prev && busy === 1'b1 && acc_n < 3) begin
                acc_at[acc_n] = n;
                acc_n++;
                if (acc_n < 3) begin
                    op_a = av[acc_n]; op_b = bv[acc_n]; cin = cv[acc_n];
                end else begin
                    start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
                end
            end
            busy_prev = busy;
        end
        start = 1'b0;
        checks++;
        if (done_n != 3 || acc_n != 3) begin
            failures++;
            $display("FAIL b2b count: got %0d accepts %0d dones want 3 and 3", acc_n, done_n);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (done_at[i] - acc_at[i] != LAT) begin
                failures++;
                $display("FAIL b2b latency%0d: got %0d want %0d", i, done_at[i] - acc_at[i], LAT);
            end
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (acc_at[i+1] != done_at[i] + 1) begin
                failures++;
                $display("FAIL b2b gap%0d: got accept at %0d want %0d", i, acc_at[i+1], done_at[i] + 1);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            c = 1'($urandom_range(0, 1));
            do_op(a, b, c, "rand");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_ripple();
        test_start_ignored();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
